// File: rtl/fd_pkg.sv
// Shared definitions for the integral-image window scheduler: FSM encoding
// and window-count helpers derived from the scan geometry.
package fd_pkg;

   // Scheduler FSM encoding
   typedef logic [2:0] state_t;

   localparam state_t StIdle    = 3'd0;
   localparam state_t StLaunch  = 3'd1;
   localparam state_t StWait    = 3'd2;
   localparam state_t StAdvance = 3'd3;
   localparam state_t StDone    = 3'd4;

   // Number of window positions along one axis
   function automatic int unsigned win_count(input int unsigned img, input int unsigned win,
                                             input int unsigned step);
      return (img - win) / step + 1;
   endfunction

   // Window counts for the default 160x120 frame, 24-pixel window, stride 4
   localparam int unsigned NX = win_count(160, 24, 4);
   localparam int unsigned NY = win_count(120, 24, 4);

endpackage

// File: rtl/ii_window_scheduler_if.sv
// Handshake bundle between the scheduler, the capture path and the cascade.
// `continue` is a reserved word, so the rescan-mode input is named `continuous`.
interface ii_window_scheduler_if #(
   parameter int unsigned AW = 15
);
   logic          cap_done;
   logic          continuous;
   logic          arm;
   logic          detect_done;
   logic          detected_flag;
   logic          buf_lock;
   logic          detect_en;
   logic [AW-1:0] win_base_addr;
   logic [7:0]    win_x;
   logic [7:0]    win_y;
   logic          busy;
   logic          scan_done;
   logic [9:0]    hit_count;
   logic [7:0]    first_hit_x;
   logic [7:0]    first_hit_y;
   logic          timeout_err;

   // Environment side: capture path, control and cascade
   modport master (
      output cap_done, continuous, arm, detect_done, detected_flag,
      input  buf_lock, detect_en, win_base_addr, win_x, win_y, busy, scan_done,
             hit_count, first_hit_x, first_hit_y, timeout_err
   );

   // Scheduler side
   modport slave (
      input  cap_done, continuous, arm, detect_done, detected_flag,
      output buf_lock, detect_en, win_base_addr, win_x, win_y, busy, scan_done,
             hit_count, first_hit_x, first_hit_y, timeout_err
   );
endinterface

// File: rtl/ii_window_stepper.sv
// Window position counters. Keeps x/y and the buffer base address in step
// incrementally so no multiplier is needed: base = y*IMG_W + x by construction.
module ii_window_stepper
   import fd_pkg::*;
#(
   parameter int unsigned IMG_W = 160,
   parameter int unsigned IMG_H = 120,
   parameter int unsigned WIN   = 24,
   parameter int unsigned STEP  = 4,
   parameter int unsigned AW    = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          step,
   output logic [7:0]    win_x,
   output logic [7:0]    win_y,
   output logic [AW-1:0] win_base_addr,
   output logic          last_window
);

   localparam int unsigned NumX = win_count(IMG_W, WIN, STEP);
   localparam int unsigned NumY = win_count(IMG_H, WIN, STEP);

   // Positions are always multiples of STEP, so the last column/row is a fixed value
   localparam logic [7:0]    XLast   = 8'((NumX - 1) * STEP);
   localparam logic [7:0]    YLast   = 8'((NumY - 1) * STEP);
   localparam logic [7:0]    StepPx  = 8'(STEP);
   localparam logic [AW-1:0] StepA   = AW'(STEP);
   localparam logic [AW-1:0] RowStep = AW'(STEP * IMG_W);

   logic [7:0]    x_q, y_q;
   logic [AW-1:0] row_q, addr_q;
   logic          last_x, last_y;

   assign last_x = (x_q == XLast);
   assign last_y = (y_q == YLast);

   // Raster-order position update; clear rewinds to the top-left window
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         x_q    <= '0;
         y_q    <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else if (step) begin
         if (!last_x) begin
            x_q    <= x_q + StepPx;
            addr_q <= addr_q + StepA;
         end else if (!last_y) begin
            x_q    <= '0;
            y_q    <= y_q + StepPx;
            row_q  <= row_q + RowStep;
            addr_q <= row_q + RowStep;
         end
      end
   end

   assign win_x         = x_q;
   assign win_y         = y_q;
   assign win_base_addr = addr_q;
   assign last_window   = last_x && last_y;

endmodule

// File: rtl/ii_window_scheduler.sv
// Scans every window of a captured integral-image frame through the cascade,
// holding the buffer locked for the duration and accumulating hit results.
module ii_window_scheduler
   import fd_pkg::*;
#(
   parameter int unsigned IMG_W   = 160,
   parameter int unsigned IMG_H   = 120,
   parameter int unsigned WIN     = 24,
   parameter int unsigned STEP    = 4,
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned AW      = 15
) (
   input logic                 clk,
   input logic                 rst,
   ii_window_scheduler_if.slave bus
);

   localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   // A window larger than the frame leaves no legal position to scan
   if (WIN > IMG_W || WIN > IMG_H || STEP == 0 || TIMEOUT == 0) begin : g_bad_geometry
      $fatal(1, "ii_window_scheduler: illegal geometry or timeout parameters");
   end

   state_t         state_q, state_d;
   logic           armed_q, armed_d;
   logic           buf_lock_q, buf_lock_d;
   logic           busy_q, busy_d;
   logic [9:0]     hit_q, hit_d;
   logic [7:0]     first_x_q, first_x_d;
   logic [7:0]     first_y_q, first_y_d;
   logic           timeout_q, timeout_d;
   logic [WdW-1:0] wd_q, wd_d;
   logic           start, clear, step, last_window;

   assign start = (state_q == StIdle) && bus.cap_done && (armed_q || bus.continuous);

   ii_window_stepper #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .WIN   (WIN),
      .STEP  (STEP),
      .AW    (AW)
   ) u_stepper (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .step          (step),
      .win_x         (bus.win_x),
      .win_y         (bus.win_y),
      .win_base_addr (bus.win_base_addr),
      .last_window   (last_window)
   );

   // Next-state, result accumulation and watchdog
   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      buf_lock_d = buf_lock_q;
      busy_d     = busy_q;
      hit_d      = hit_q;
      first_x_d  = first_x_q;
      first_y_d  = first_y_q;
      timeout_d  = timeout_q;
      wd_d       = wd_q;
      clear      = 1'b0;
      step       = 1'b0;

      if (bus.arm) armed_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLaunch;
               armed_d    = 1'b0;
               buf_lock_d = 1'b1;
               busy_d     = 1'b1;
               hit_d      = '0;
               first_x_d  = '0;
               first_y_d  = '0;
               timeout_d  = 1'b0;
               clear      = 1'b1;
            end
         end
         StLaunch: begin
            state_d = StWait;
            wd_d    = '0;
         end
         StWait: begin
            // A result arriving on the timeout cycle wins over the timeout
            if (bus.detect_done) begin
               if (bus.detected_flag) begin
                  if (hit_q != 10'h3ff) hit_d = hit_q + 10'd1;
                  if (hit_q == '0) begin
                     first_x_d = bus.win_x;
                     first_y_d = bus.win_y;
                  end
               end
               state_d = StAdvance;
            end else if (wd_q == WdLast) begin
               timeout_d = 1'b1;
               state_d   = StAdvance;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StAdvance: begin
            if (last_window) begin
               state_d = StDone;
            end else begin
               step    = 1'b1;
               state_d = StLaunch;
            end
         end
         StDone: begin
            buf_lock_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         armed_q    <= 1'b0;
         buf_lock_q <= 1'b0;
         busy_q     <= 1'b0;
         hit_q      <= '0;
         first_x_q  <= '0;
         first_y_q  <= '0;
         timeout_q  <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         buf_lock_q <= buf_lock_d;
         busy_q     <= busy_d;
         hit_q      <= hit_d;
         first_x_q  <= first_x_d;
         first_y_q  <= first_y_d;
         timeout_q  <= timeout_d;
         wd_q       <= wd_d;
      end
   end

   assign bus.detect_en   = (state_q == StLaunch);
   assign bus.scan_done   = (state_q == StDone);
   assign bus.buf_lock    = buf_lock_q;
   assign bus.busy        = busy_q;
   assign bus.hit_count   = hit_q;
   assign bus.first_hit_x = first_x_q;
   assign bus.first_hit_y = first_y_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_ii_window_scheduler.sv
// Directed bench for ii_window_scheduler on a 32x28 frame (3x2 windows).
module tb_ii_window_scheduler;

   localparam int unsigned IMG_W   = 32;
   localparam int unsigned IMG_H   = 28;
   localparam int unsigned WIN     = 24;
   localparam int unsigned STEP    = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned AW      = 15;

   logic clk;
   logic rst;

   ii_window_scheduler_if #(.AW(AW)) bus ();

   ii_window_scheduler #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .WIN     (WIN),
      .STEP    (STEP),
      .TIMEOUT (TIMEOUT),
      .AW      (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Cascade model and monitor state
   int en_count = 0;
   int sd_count = 0;
   int cyc      = 0;
   int addr_q[$];
   int en_cyc_q[$];
   int skip_at  = -1;
   int hit_a    = -1;
   int hit_b    = -1;
   int resp_cnt = 0;
   bit resp_flag = 1'b0;

   int exp_addr[6] = '{0, 4, 8, 128, 132, 136};

   // Cascade answers 3 cycles after each detect_en; records enables and scan_done pulses
   initial begin
      bus.detect_done   = 1'b0;
      bus.detected_flag = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.detect_done   = 1'b0;
         bus.detected_flag = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.detect_done   = 1'b1;
               bus.detected_flag = resp_flag;
            end
         end
         if (bus.scan_done) sd_count++;
         if (bus.detect_en) begin
            addr_q.push_back(int'(bus.win_base_addr));
            en_cyc_q.push_back(cyc);
            if (en_count != skip_at) begin
               resp_cnt  = 3;
               resp_flag = (int'(bus.win_base_addr) == hit_a) ||
                           (int'(bus.win_base_addr) == hit_b);
            end
            en_count++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ends at the negedge of the cycle after cap_done was sampled
   task automatic start_scan(input bit do_arm);
      if (do_arm) begin
         @(negedge clk);
         bus.arm = 1'b1;
         @(negedge clk);
         bus.arm = 1'b0;
      end else begin
         @(negedge clk);
      end
      bus.cap_done = 1'b1;
      @(negedge clk);
      bus.cap_done = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.scan_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_addrs(input int base, input string name);
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (base + i >= addr_q.size()) begin
            tests_failed++;
            $display("FAIL %s addr[%0d]: missing, required %0d", name, i, exp_addr[i]);
         end else if (addr_q[base+i] !== exp_addr[i]) begin
            tests_failed++;
            $display("FAIL %s addr[%0d]: got %0d, required %0d", name, i, addr_q[base+i],
                     exp_addr[i]);
         end
      end
   endtask

   task automatic test_reset();
      logic [63:0] outs;
      rst = 1'b1;
      bus.cap_done = 1'b0;
      bus.continuous = 1'b0;
      bus.arm = 1'b0;
      tick(4);
      outs = {bus.buf_lock, bus.detect_en, bus.win_base_addr, bus.win_x, bus.win_y, bus.busy,
              bus.scan_done, bus.hit_count, bus.first_hit_x, bus.first_hit_y, bus.timeout_err};
      tests_run++;
      if (outs !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, required 0", outs);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_basic_scan();
      int  base = en_count;
      int  sd0  = sd_count;
      int  lock_bad = 0;
      bit  ok = 1'b0;
      start_scan(1'b1);
      tests_run++;
      if (bus.detect_en !== 1'b1 || bus.win_base_addr !== '0 || bus.buf_lock !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_launch: en=%b addr=%0d lock=%b, required 1/0/1", bus.detect_en,
                  bus.win_base_addr, bus.buf_lock);
      end
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.buf_lock !== 1'b1) lock_bad++;
         if (bus.scan_done) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok || lock_bad != 0) begin
         tests_failed++;
         $display("FAIL basic_lock_until_done: done=%b lock_low_cycles=%0d, required 1/0", ok,
                  lock_bad);
      end
      tick(1);
      tests_run++;
      if (bus.buf_lock !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_release: lock=%b busy=%b, required 0/0", bus.buf_lock, bus.busy);
      end
      tick(4);
      tests_run++;
      if (en_count - base != 6 || sd_count - sd0 != 1) begin
         tests_failed++;
         $display("FAIL basic_counts: en=%0d done=%0d, required 6/1", en_count - base,
                  sd_count - sd0);
      end
      check_addrs(base, "basic");
      tests_run++;
      if (en_cyc_q.size() < base + 2 || en_cyc_q[base+1] - en_cyc_q[base] != 5) begin
         tests_failed++;
         $display("FAIL basic_relaunch_gap: got %0d cycles, required 5",
                  (en_cyc_q.size() < base + 2) ? -1 : en_cyc_q[base+1] - en_cyc_q[base]);
      end
      tests_run++;
      if (bus.hit_count !== 10'd0 || bus.timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_results: hits=%0d to=%b, required 0/0", bus.hit_count,
                  bus.timeout_err);
      end
   endtask

   task automatic test_hits();
      bit ok;
      hit_a = 132;  // window at (4,4)
      hit_b = 136;  // window at (8,4)
      start_scan(1'b1);
      wait_done(400, ok);
      tick(2);
      tests_run++;
      if (!ok || bus.hit_count !== 10'd2 || bus.first_hit_x !== 8'd4 ||
          bus.first_hit_y !== 8'd4) begin
         tests_failed++;
         $display("FAIL hits: done=%b hits=%0d first=(%0d,%0d), required 1/2/(4,4)", ok,
                  bus.hit_count, bus.first_hit_x, bus.first_hit_y);
      end
      hit_a = -1;
      hit_b = -1;
   endtask

   task automatic test_timeout();
      int base = en_count;
      bit ok;
      skip_at = base + 1;  // second window never answered
      start_scan(1'b1);
      wait_done(600, ok);
      tick(2);
      tests_run++;
      if (!ok || bus.timeout_err !== 1'b1 || en_count - base != 6) begin
         tests_failed++;
         $display("FAIL timeout: done=%b to=%b en=%0d, required 1/1/6", ok, bus.timeout_err,
                  en_count - base);
      end
      // LAUNCH, 16 WAIT cycles, ADVANCE, then the next LAUNCH
      tests_run++;
      if (en_cyc_q.size() < base + 3 || en_cyc_q[base+2] - en_cyc_q[base+1] != 18) begin
         tests_failed++;
         $display("FAIL timeout_gap: got %0d cycles, required 18",
                  (en_cyc_q.size() < base + 3) ? -1 : en_cyc_q[base+2] - en_cyc_q[base+1]);
      end
      check_addrs(base, "timeout");
      skip_at = -1;
   endtask

   task automatic test_no_arm();
      int base = en_count;
      int busy_seen = 0;
      start_scan(1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) busy_seen++;
      end
      tests_run++;
      if (en_count - base != 0 || busy_seen != 0) begin
         tests_failed++;
         $display("FAIL no_arm: en=%0d busy_cycles=%0d, required 0/0", en_count - base,
                  busy_seen);
      end
   endtask

   task automatic test_continuous();
      int base = en_count;
      int sd0  = sd_count;
      bit ok1, ok2;
      bus.continuous = 1'b1;
      start_scan(1'b0);
      tests_run++;
      if (bus.timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL cont_clear_timeout: got %b, required 0", bus.timeout_err);
      end
      wait_done(400, ok1);
      tick(1);
      start_scan(1'b0);
      wait_done(400, ok2);
      tick(1);
      bus.continuous = 1'b0;
      tick(3);
      tests_run++;
      if (!ok1 || !ok2 || en_count - base != 12 || sd_count - sd0 != 2) begin
         tests_failed++;
         $display("FAIL continuous: done=%b%b en=%0d scans=%0d, required 11/12/2", ok1, ok2,
                  en_count - base, sd_count - sd0);
      end
   endtask

   task automatic test_reset_mid_scan();
      int          sd0 = sd_count;
      int          base;
      bit          found = 1'b0;
      bit          ok;
      logic [63:0] outs;
      start_scan(1'b1);
      for (int i = 0; i < 200; i++) begin
         if (bus.detect_en && bus.win_base_addr == AW'(8)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      tick(1);  // now in WAIT of the third window
      rst = 1'b1;
      tick(1);
      outs = {bus.buf_lock, bus.detect_en, bus.win_base_addr, bus.win_x, bus.win_y, bus.busy,
              bus.scan_done, bus.hit_count, bus.first_hit_x, bus.first_hit_y, bus.timeout_err};
      rst = 1'b0;
      tests_run++;
      if (!found || outs !== '0) begin
         tests_failed++;
         $display("FAIL rst_mid_scan: reached=%b outs=%h, required 1/0", found, outs);
      end
      tick(10);
      tests_run++;
      if (sd_count != sd0) begin
         tests_failed++;
         $display("FAIL rst_no_done: got %0d pulses, required 0", sd_count - sd0);
      end
      base = en_count;
      start_scan(1'b1);
      wait_done(400, ok);
      tick(3);
      tests_run++;
      if (!ok || en_count - base != 6) begin
         tests_failed++;
         $display("FAIL rst_restart: done=%b en=%0d, required 1/6", ok, en_count - base);
      end
      check_addrs(base, "restart");
   endtask

   task automatic test_cap_mid_scan();
      int base = en_count;
      int sd0  = sd_count;
      bit ok;
      bus.continuous = 1'b1;
      start_scan(1'b0);
      tick(10);
      bus.cap_done = 1'b1;
      tick(1);
      bus.cap_done = 1'b0;
      wait_done(400, ok);
      tick(1);
      bus.continuous = 1'b0;
      tick(20);
      tests_run++;
      if (!ok || en_count - base != 6 || sd_count - sd0 != 1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL cap_mid_scan: done=%b en=%0d scans=%0d busy=%b, required 1/6/1/0", ok,
                  en_count - base, sd_count - sd0, bus.busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.cap_done = 1'b0;
      bus.continuous = 1'b0;
      bus.arm = 1'b0;
      test_reset();
      test_basic_scan();
      test_hits();
      test_timeout();
      test_no_arm();
      test_continuous();
      test_reset_mid_scan();
      test_cap_mid_scan();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
